// File: rtl/gpio_pkg.sv
// Shared constants and types for the GPIO controller: register map, word width, bus FSM states.
package gpio_pkg;

  localparam int unsigned GPIO_W = 32;
  localparam int unsigned CTI_W  = 3;

  localparam logic [7:0] GPIO_OUT     = 8'h00;
  localparam logic [7:0] GPIO_DIR     = 8'h04;
  localparam logic [7:0] GPIO_IN      = 8'h08;
  localparam logic [7:0] GPIO_RISE_EN = 8'h0C;
  localparam logic [7:0] GPIO_FALL_EN = 8'h10;
  localparam logic [7:0] GPIO_PEND    = 8'h14;
  localparam logic [7:0] GPIO_SET     = 8'h18;
  localparam logic [7:0] GPIO_CLR     = 8'h1C;

  typedef enum logic [1:0] {
    BUS_IDLE = 2'd0,
    BUS_ACK  = 2'd1,
    BUS_ERR  = 2'd2
  } bus_state_e;

  // True for word-aligned offsets inside the 0x00..0x1C register block.
  function automatic logic offset_mapped(input logic [7:0] off);
    return (off[7:5] == 3'b000) && (off[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/gpio_if.sv
// Wishbone classic slave bus bundle for the GPIO controller.
interface gpio_if;

  logic                          STB;
  logic                          CYC;
  logic                          WE;
  logic [gpio_pkg::GPIO_W-1:0]   ADR;
  logic [gpio_pkg::GPIO_W-1:0]   DAT_O;
  logic [gpio_pkg::GPIO_W-1:0]   DAT_I;
  logic [gpio_pkg::CTI_W-1:0]    CTI_O;
  logic                          ACK;
  logic                          ERR;
  logic                          RTY;

  modport master (
    output STB, CYC, WE, ADR, DAT_O, CTI_O,
    input  DAT_I, ACK, ERR, RTY
  );

  modport slave (
    input  STB, CYC, WE, ADR, DAT_O, CTI_O,
    output DAT_I, ACK, ERR, RTY
  );

endinterface

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for asynchronous pad inputs; q is the last stage.
module sync_ff #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] stage_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q <= '0;
    end else begin
      stage_q <= {stage_q[STAGES-2:0], d};
    end
  end

  assign q = stage_q[STAGES-1];

endmodule

// File: rtl/gpio_ctrl.sv
// 32-bit GPIO block on a Wishbone classic slave: register file, pad drivers,
// synchronized inputs with edge-triggered pending bits and a level interrupt.
module gpio_ctrl
  import gpio_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  gpio_if.slave             bus,
  inout  wire  [GPIO_W-1:0] gpio,
  output logic              irq
);

  logic [GPIO_W-1:0] out_q, dir_q, rise_en_q, fall_en_q, pend_q, prev_q;
  logic [GPIO_W-1:0] in_s;
  logic [GPIO_W-1:0] pend_d;
  logic [GPIO_W-1:0] rdata_c;
  logic [GPIO_W-1:0] rise_c, fall_c;
  logic [7:0]        off_c;
  logic              req_c, bad_c, wr_c;
  bus_state_e        state_q, state_d;
  logic              ack_q, err_q, ack_d, err_d;
  logic [GPIO_W-1:0] dat_q, dat_d;

  logic unused_bus;
  assign unused_bus = ^{bus.CTI_O, bus.ADR[GPIO_W-1:8]};

  // Pad drivers: output only where DIR selects it.
  for (genvar i = 0; i < int'(GPIO_W); i++) begin : g_pad
    assign gpio[i] = dir_q[i] ? out_q[i] : 1'bz;
  end

  sync_ff #(
    .WIDTH  (GPIO_W),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (gpio),
    .q   (in_s)
  );

  // Decode: a request is taken only while no termination is in flight.
  assign off_c = bus.ADR[7:0];
  assign req_c = bus.STB & bus.CYC & (state_q == BUS_IDLE);
  assign bad_c = !offset_mapped(off_c) || (bus.WE && (off_c == GPIO_IN));
  assign wr_c  = req_c & bus.WE & ~bad_c;

  always_comb begin
    rdata_c = '0;
    unique case (off_c)
      GPIO_OUT:     rdata_c = out_q;
      GPIO_DIR:     rdata_c = dir_q;
      GPIO_IN:      rdata_c = in_s;
      GPIO_RISE_EN: rdata_c = rise_en_q;
      GPIO_FALL_EN: rdata_c = fall_en_q;
      GPIO_PEND:    rdata_c = pend_q;
      default:      rdata_c = '0;
    endcase
  end

  // Edges on output-direction bits are loopback, not events.
  assign rise_c =  in_s & ~prev_q & ~dir_q;
  assign fall_c = ~in_s &  prev_q & ~dir_q;

  // W1C is applied first so a same-cycle edge wins.
  always_comb begin
    pend_d = pend_q;
    if (wr_c && (off_c == GPIO_PEND)) begin
      pend_d = pend_d & ~bus.DAT_O;
    end
    pend_d = pend_d | (rise_c & rise_en_q) | (fall_c & fall_en_q);
  end

  // Bus FSM next state and registered termination/data outputs.
  always_comb begin
    state_d = BUS_IDLE;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    dat_d   = '0;
    if (req_c) begin
      if (bad_c) begin
        state_d = BUS_ERR;
        err_d   = 1'b1;
      end else begin
        state_d = BUS_ACK;
        ack_d   = 1'b1;
        if (!bus.WE) begin
          dat_d = rdata_c;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= BUS_IDLE;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      dat_q   <= dat_d;
    end
  end

  // Register file, edge history and interrupt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q     <= '0;
      dir_q     <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      pend_q    <= '0;
      prev_q    <= '0;
      irq       <= 1'b0;
    end else begin
      prev_q <= in_s;
      pend_q <= pend_d;
      irq    <= |pend_d;
      if (wr_c) begin
        unique case (off_c)
          GPIO_OUT:     out_q     <= bus.DAT_O;
          GPIO_DIR:     dir_q     <= bus.DAT_O;
          GPIO_RISE_EN: rise_en_q <= bus.DAT_O;
          GPIO_FALL_EN: fall_en_q <= bus.DAT_O;
          GPIO_SET:     out_q     <= out_q | bus.DAT_O;
          GPIO_CLR:     out_q     <= out_q & ~bus.DAT_O;
          default:      ;
        endcase
      end
    end
  end

  assign bus.ACK   = ack_q;
  assign bus.ERR   = err_q;
  assign bus.RTY   = 1'b0;
  assign bus.DAT_I = dat_q;

endmodule
